// File: rtl/trng_collector.sv
// Ring-oscillator TRNG consumer: synchronizes the raw bit, runs a repetition-count health test,
// von Neumann debiases, packs bits into words and buffers them in a small valid/ready FIFO.
module trng_collector #(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned WARMUP_CYCLES = 64,
  parameter int unsigned REP_LIMIT     = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  output logic                               trng_en,
  input  logic                               trng_in,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [WORD_WIDTH-1:0]              rd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               health_err
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WarmW = $clog2(WARMUP_CYCLES + 1);
  localparam int unsigned BitW  = $clog2(WORD_WIDTH);
  localparam int unsigned RepW  = $clog2(REP_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StWarmup, StCollect, StError} state_e;

  state_e                state_q;
  logic                  trng_en_q;
  logic                  health_err_q;
  logic                  sync1_q;
  logic                  s_q;
  logic [WarmW-1:0]      warm_cnt_q;
  logic                  have_a_q;
  logic                  pair_a_q;
  logic                  prev_q;
  logic [RepW-1:0]       rep_q;
  logic [RepW-1:0]       rep_d;
  logic [WORD_WIDTH-1:0] word_q;
  logic [WORD_WIDTH-1:0] word_shift;
  logic [BitW-1:0]       bit_cnt_q;
  logic                  pend_valid_q;
  logic [WORD_WIDTH-1:0] pend_q;
  logic [WORD_WIDTH-1:0] push_data;

  logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [LvlW-1:0]       level_q;

  logic pop;
  logic full;
  logic space;
  logic collecting;
  logic health_fail;
  logic emit;
  logic word_done;
  logic push;

  assign trng_en    = trng_en_q;
  assign health_err = health_err_q;
  assign rd_valid   = (level_q != '0);
  assign rd_data    = mem_q[rd_ptr_q];
  assign fifo_level = level_q;

  always_comb begin
    pop         = rd_valid && rd_ready;
    full        = (level_q == LvlW'(FIFO_DEPTH));
    space       = !full || pop;
    collecting  = (state_q == StCollect) && enable;
    // rep_q == 0 marks the first COLLECT sample, which always starts a new run.
    rep_d       = ((rep_q == '0) || (s_q != prev_q)) ? RepW'(1) : rep_q + RepW'(1);
    health_fail = collecting && (rep_d == RepW'(REP_LIMIT));
    emit        = collecting && have_a_q && (pair_a_q != s_q);
    word_shift  = {word_q[WORD_WIDTH-2:0], pair_a_q};
    word_done   = emit && !pend_valid_q && (bit_cnt_q == BitW'(WORD_WIDTH - 1));
    push        = 1'b0;
    push_data   = word_shift;
    if (collecting && !health_fail) begin
      if (pend_valid_q && space) begin
        push      = 1'b1;
        push_data = pend_q;
      end else if (word_done && space) begin
        push      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= trng_in;
      s_q     <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LvlW'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      trng_en_q    <= 1'b0;
      health_err_q <= 1'b0;
      warm_cnt_q   <= '0;
      have_a_q     <= 1'b0;
      pair_a_q     <= 1'b0;
      prev_q       <= 1'b0;
      rep_q        <= '0;
      word_q       <= '0;
      bit_cnt_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable) begin
            state_q      <= StWarmup;
            trng_en_q    <= 1'b1;
            warm_cnt_q   <= '0;
            have_a_q     <= 1'b0;
            word_q       <= '0;
            bit_cnt_q    <= '0;
            rep_q        <= '0;
            pend_valid_q <= 1'b0;
          end
        end
        StWarmup: begin
          if (!enable) begin
            state_q   <= StIdle;
            trng_en_q <= 1'b0;
          end else if (warm_cnt_q == WarmW'(WARMUP_CYCLES - 1)) begin
            state_q <= StCollect;
          end else begin
            warm_cnt_q <= warm_cnt_q + WarmW'(1);
          end
        end
        StCollect: begin
          if (!enable || health_fail) begin
            state_q      <= enable ? StError : StIdle;
            trng_en_q    <= 1'b0;
            health_err_q <= enable;
            have_a_q     <= 1'b0;
            word_q       <= '0;
            bit_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
          end else begin
            rep_q    <= rep_d;
            prev_q   <= s_q;
            have_a_q <= !have_a_q;
            if (!have_a_q) begin
              pair_a_q <= s_q;
            end
            // While a word is pending, emitted bits are dropped until it drains.
            if (pend_valid_q) begin
              if (space) begin
                pend_valid_q <= 1'b0;
                word_q       <= '0;
                bit_cnt_q    <= '0;
              end
            end else if (emit) begin
              if (word_done) begin
                word_q    <= '0;
                bit_cnt_q <= '0;
                if (!space) begin
                  pend_valid_q <= 1'b1;
                  pend_q       <= word_shift;
                end
              end else begin
                word_q    <= word_shift;
                bit_cnt_q <= bit_cnt_q + BitW'(1);
              end
            end
          end
        end
        StError: begin
          if (!enable) begin
            state_q      <= StIdle;
            health_err_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// Randomized and directed bench for trng_collector against a queue-based behavioural model.
module tb_trng_collector;

  localparam int unsigned WW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WARM  = 64;
  localparam int unsigned REP   = 32;
  localparam int unsigned LvlW  = $clog2(DEPTH + 1);

  localparam int MIdle = 0;
  localparam int MWarm = 1;
  localparam int MColl = 2;
  localparam int MErr  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            trng_en;
  logic            trng_in;
  logic            rd_valid;
  logic            rd_ready;
  logic [WW-1:0]   rd_data;
  logic [LvlW-1:0] fifo_level;
  logic            health_err;

  always #5 clk = ~clk;

  trng_collector #(
    .WORD_WIDTH   (WW),
    .FIFO_DEPTH   (DEPTH),
    .WARMUP_CYCLES(WARM),
    .REP_LIMIT    (REP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .trng_en   (trng_en),
    .trng_in   (trng_in),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .fifo_level(fifo_level),
    .health_err(health_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  int            m_mode = MIdle;
  int            m_warm = 0;
  int            m_run = 0;
  int            m_nbits = 0;
  bit            m_last = 0;
  bit            m_have = 0;
  bit            m_first = 0;
  bit            m_ten = 0;
  bit            m_herr = 0;
  bit            m_pend = 0;
  bit            m_s1 = 0;
  bit            m_s2 = 0;
  logic [WW-1:0] m_word = '0;
  logic [WW-1:0] m_pend_word = '0;
  logic [WW-1:0] m_fifo[$];

  task automatic model_step(input bit rst, input bit en, input bit tin, input bit rdy);
    bit            pop;
    bit            space;
    bit            s;
    bit            was_pend;
    bit            have_push;
    logic [WW-1:0] push_w;
    if (rst) begin
      m_mode = MIdle; m_warm = 0; m_run = 0; m_nbits = 0; m_have = 0; m_ten = 0;
      m_herr = 0; m_pend = 0; m_s1 = 0; m_s2 = 0; m_word = '0; m_last = 0;
      m_fifo.delete();
      return;
    end
    pop       = (m_fifo.size() != 0) && rdy;
    space     = (m_fifo.size() < DEPTH) || pop;
    s         = m_s2;
    have_push = 0;
    push_w    = '0;
    case (m_mode)
      MIdle: begin
        if (en) begin
          m_mode = MWarm; m_warm = 0; m_ten = 1; m_have = 0; m_nbits = 0;
          m_word = '0; m_run = 0; m_pend = 0;
        end
      end
      MWarm: begin
        if (!en) begin
          m_mode = MIdle; m_ten = 0;
        end else begin
          m_warm++;
          if (m_warm == WARM) m_mode = MColl;
        end
      end
      MColl: begin
        if (!en) begin
          m_mode = MIdle; m_ten = 0; m_have = 0; m_nbits = 0; m_word = '0; m_pend = 0;
        end else begin
          m_run  = (m_run == 0 || s != m_last) ? 1 : m_run + 1;
          m_last = s;
          if (m_run >= REP) begin
            m_mode = MErr; m_herr = 1; m_ten = 0; m_pend = 0; m_nbits = 0; m_have = 0;
            m_word = '0;
          end else begin
            was_pend = m_pend;
            if (was_pend && space) begin
              push_w = m_pend_word; have_push = 1; m_pend = 0; m_nbits = 0; m_word = '0;
            end
            if (!m_have) begin
              m_first = s; m_have = 1;
            end else begin
              m_have = 0;
              if (m_first != s && !was_pend) begin
                m_word = {m_word[WW-2:0], m_first};
                m_nbits++;
                if (m_nbits == WW) begin
                  m_nbits = 0;
                  if (space) begin
                    push_w = m_word; have_push = 1;
                  end else begin
                    m_pend = 1; m_pend_word = m_word;
                  end
                  m_word = '0;
                end
              end
            end
          end
        end
      end
      default: begin
        if (!en) begin
          m_mode = MIdle; m_herr = 0;
        end
      end
    endcase
    if (pop) void'(m_fifo.pop_front());
    if (have_push) m_fifo.push_back(push_w);
    m_s2 = m_s1;
    m_s1 = tin;
  endtask

  task automatic compare_outputs();
    check_eq("trng_en", 64'(trng_en), 64'(m_ten));
    check_eq("rd_valid", 64'(rd_valid), 64'(m_fifo.size() != 0));
    check_eq("fifo_level", 64'(fifo_level), 64'(m_fifo.size()));
    check_eq("health_err", 64'(health_err), 64'(m_herr));
    if (m_fifo.size() != 0) check_eq("rd_data", 64'(rd_data), 64'(m_fifo[0]));
  endtask

  // Stimulus: pattern mode aligns pat[0] with the first COLLECT sample after enable at e_cycle.
  int n = 0;
  int e_cycle = 0;
  bit use_pat = 0;
  int pat[$];

  task automatic tick(input bit rst, input bit en, input bit rdy);
    bit tin;
    int len;
    int idx;
    if (use_pat) begin
      len = pat.size();
      idx = (((n - e_cycle - int'(WARM) + 1) % len) + len) % len;
      tin = (pat[idx] != 0);
    end else begin
      tin = 1'($urandom_range(0, 1));
    end
    reset    = rst;
    enable   = en;
    rd_ready = rdy;
    trng_in  = tin;
    @(posedge clk);
    model_step(rst, en, tin, rdy);
    n++;
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    int k;
    int drained;
    bit en_r;
    reset = 1'b1; enable = 1'b0; rd_ready = 1'b0; trng_in = 1'b0;

    // Reset
    repeat (3) tick(1, 0, 0);
    check_eq("reset_rd_data", 64'(rd_data), 64'h0);
    check_eq("reset_trng_en", 64'(trng_en), 64'h0);
    tick(0, 0, 0);

    // Debias 1,0,0,1 -> 0xAAAAAAAA
    use_pat = 1; pat = '{1, 0, 0, 1}; e_cycle = n;
    k = 0;
    while (!rd_valid && k < 400) begin tick(0, 1, 0); k++; end
    check_eq("debias_valid", 64'(rd_valid), 64'h1);
    check_eq("debias_word", 64'(rd_data), 64'hAAAA_AAAA);
    tick(0, 1, 1);
    repeat (2) tick(0, 0, 0);

    // Discarded pairs 1,1,0,0,1,0 -> 0xFFFFFFFF
    pat = '{1, 1, 0, 0, 1, 0}; e_cycle = n;
    k = 0;
    while (!rd_valid && k < 600) begin tick(0, 1, 0); k++; end
    check_eq("discard_valid", 64'(rd_valid), 64'h1);
    check_eq("discard_word", 64'(rd_data), 64'hFFFF_FFFF);
    check_eq("discard_herr", 64'(health_err), 64'h0);
    tick(0, 1, 1);
    repeat (2) tick(0, 0, 0);

    // Backpressure: four words plus one pending
    pat = '{1, 0}; e_cycle = n;
    k = 0;
    while (fifo_level != LvlW'(DEPTH) && k < 700) begin tick(0, 1, 0); k++; end
    check_eq("bp_full", 64'(fifo_level), 64'(DEPTH));
    repeat (70) tick(0, 1, 0);
    check_eq("bp_hold", 64'(fifo_level), 64'(DEPTH));
    check_eq("bp_head", 64'(rd_data), 64'hFFFF_FFFF);
    tick(0, 1, 1);
    check_eq("bp_pop_level", 64'(fifo_level), 64'(DEPTH));
    tick(0, 0, 0);
    drained = 1;
    k = 0;
    while (rd_valid && k < 10) begin
      check_eq("bp_drain_word", 64'(rd_data), 64'hFFFF_FFFF);
      tick(0, 0, 1);
      drained++; k++;
    end
    check_eq("bp_drain_count", 64'(drained), 64'd5);

    // Health: constant 1
    pat = '{1}; e_cycle = n;
    k = 0;
    while (!health_err && k < 300) begin tick(0, 1, 0); k++; end
    check_eq("health_latency", 64'(k), 64'(WARM + 33));
    check_eq("health_trng_en", 64'(trng_en), 64'h0);
    check_eq("health_no_word", 64'(fifo_level), 64'h0);
    repeat (3) tick(0, 1, 0);
    check_eq("health_sticky", 64'(health_err), 64'h1);
    tick(0, 0, 0);
    check_eq("health_clear", 64'(health_err), 64'h0);
    tick(0, 0, 0);

    // Abort after 10 emitted ones, then fresh zeros
    pat = '{1, 0}; e_cycle = n;
    repeat (WARM + 21) tick(0, 1, 0);
    tick(0, 0, 0);
    pat = '{0, 1}; e_cycle = n;
    k = 0;
    while (!rd_valid && k < 400) begin tick(0, 1, 0); k++; end
    check_eq("abort_latency", 64'(k), 64'(WARM + 65));
    check_eq("abort_word", 64'(rd_data), 64'h0);

    // Reset with full FIFO
    tick(0, 0, 1);
    tick(0, 0, 0);
    pat = '{1, 0}; e_cycle = n;
    k = 0;
    while (fifo_level != LvlW'(DEPTH) && k < 700) begin tick(0, 1, 0); k++; end
    check_eq("rst_full", 64'(fifo_level), 64'(DEPTH));
    tick(1, 1, 0);
    check_eq("rst_trng_en", 64'(trng_en), 64'h0);
    check_eq("rst_rd_valid", 64'(rd_valid), 64'h0);
    check_eq("rst_rd_data", 64'(rd_data), 64'h0);
    check_eq("rst_level", 64'(fifo_level), 64'h0);
    check_eq("rst_herr", 64'(health_err), 64'h0);
    tick(1, 1, 0);
    check_eq("rst_hold_en", 64'(trng_en), 64'h0);
    tick(0, 1, 0);
    check_eq("rst_release_en", 64'(trng_en), 64'h1);
    repeat (2) tick(0, 0, 0);

    // Random traffic
    use_pat = 0;
    en_r = 1;
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0) en_r = !en_r;
      tick(($urandom_range(0, 1499) == 0), en_r, ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
